mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: four-requester arbiter in front of a single-port memory.
// Each transaction runs IDLE -> ADDR -> DATA -> IDLE, and every output is registered.
// A locked requester keeps exclusive access until it drops lock or req.
// Default arbitration is round-robin. Define MEM_ARBITER_FIXED_PRIO_EN to get
// fixed priority instead (lowest index wins). Lock behaviour is the same in both builds.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [3:0]  req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  last_gnt;
  logic [1:0]  lock_id;
  logic        lock_valid;
  logic        lock_rel;
  logic        cur_we;
  logic [3:0]  elig;
  logic [1:0]  win;
  logic        win_vld;

  // Eligibility mask and winner selection. Both are evaluated every cycle and used only in IDLE.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    lock_rel = lock_valid && (!lock[lock_id] || !req[lock_id]);
    elig     = req;
    if (lock_valid && !lock_rel) begin
      elig = req & (4'b0001 << lock_id);
    end
    win     = 2'd0;
    win_vld = 1'b0;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    // Scan from high to low index so the lowest set bit is the last one written.
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) begin
        win     = 2'(i);
        win_vld = 1'b1;
      end
    end
`else
    // Scan offsets from 4 down to 1 so the offset nearest last_gnt+1 is the last one written.
    for (int i = 4; i >= 1; i--) begin
      if (elig[2'(last_gnt + 2'(i))]) begin
        win     = 2'(last_gnt + 2'(i));
        win_vld = 1'b1;
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ADDR;
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs plus arbitration and lock bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= 4'b0000;
      ack        <= 4'b0000;
      rdata      <= 16'h0000;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      busy       <= 1'b0;
      lock_valid <= 1'b0;
      lock_id    <= 2'd0;
      last_gnt   <= 2'd3;
      cur_we     <= 1'b0;
    end else begin
      ack  <= 4'b0000;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (lock_rel) lock_valid <= 1'b0;
          if (win_vld) begin
            gnt       <= 4'b0001 << win;
            mem_en    <= 1'b1;
            mem_we    <= req_we[win];
            cur_we    <= req_we[win];
            mem_addr  <= req_addr[{win, 4'b0000} +: 16];
            mem_wdata <= req_wdata[{win, 4'b0000} +: 16];
            last_gnt  <= win;
            if (lock[win]) begin
              lock_valid <= 1'b1;
              lock_id    <= win;
            end
          end
        end
        ADDR: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        DATA: begin
          // On a write, rdata keeps its previous value.
          if (!cur_we) rdata <= mem_rdata;
          ack <= gnt;
          gnt <= 4'b0000;
        end
        default: begin
          gnt <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// A small memory model sits behind the arbiter. Each check is made at the negedge after the
// edge of interest.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [3:0]  req_we = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [15:0] mem_rdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;

  logic [15:0] last_wr_addr;
  logic [15:0] last_wr_data;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_rdata (mem_rdata),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Read contents: 0x40 -> 0x1234, 0x41 -> 0x5678, any other address -> {A5, addr[7:0]}.
  function automatic logic [15:0] rd_val(input logic [15:0] a);
    if (a == 16'h0040)      return 16'h1234;
    else if (a == 16'h0041) return 16'h5678;
    else                    return {8'hA5, a[7:0]};
  endfunction

  // Memory model: read data is valid one cycle after mem_en. A write leaves junk on the read bus.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        last_wr_addr <= mem_addr;
        last_wr_data <= mem_wdata;
        mem_rdata    <= 16'hDEAD;
      end else begin
        mem_rdata <= rd_val(mem_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    req_we = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] rr_exp [5];
  logic [3:0] post_lock_exp;

  initial begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    post_lock_exp = 4'b0001;
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    post_lock_exp = 4'b0100;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_ack", ack, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    rst = 1'b0;

    // Idle with no requests
    tick();
    tick();
    check("idle_gnt", gnt, 4'b0000);
    check("idle_mem_en", mem_en, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Single read by requester 0. The address change during ADDR must not reach the memory.
    req = 4'b0001;
    req_addr[15:0] = 16'h0040;
    tick();
    check("rd_gnt_addr", gnt, 4'b0001);
    check("rd_mem_en", mem_en, 1'b1);
    check("rd_mem_we", mem_we, 1'b0);
    check("rd_mem_addr", mem_addr, 16'h0040);
    check("rd_busy_addr", busy, 1'b1);
    req_addr[15:0] = 16'h0099;
    tick();
    check("rd_gnt_data", gnt, 4'b0001);
    check("rd_mem_en_data", mem_en, 1'b0);
    check("rd_busy_data", busy, 1'b1);
    check("rd_ack_data", ack, 4'b0000);
    tick();
    check("rd_ack", ack, 4'b0001);
    check("rd_rdata", rdata, 16'h1234);
    check("rd_gnt_ack", gnt, 4'b0000);
    check("rd_busy_ack", busy, 1'b0);
    req = 4'b0000;
    tick();
    check("rd_ack_pulse", ack, 4'b0000);
    check("rd_gnt_idle", gnt, 4'b0000);

    // Write by requester 2. req drops during ADDR and the transaction still completes.
    req = 4'b0100;
    req_we = 4'b0100;
    req_addr[47:32] = 16'h0010;
    req_wdata[47:32] = 16'hBEEF;
    tick();
    check("wr_gnt", gnt, 4'b0100);
    check("wr_mem_en", mem_en, 1'b1);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 16'h0010);
    check("wr_mem_wdata", mem_wdata, 16'hBEEF);
    req = 4'b0000;
    req_we = 4'b0000;
    tick();
    check("wr_mem_we_drop", mem_we, 1'b0);
    check("wr_mem_en_drop", mem_en, 1'b0);
    tick();
    check("wr_ack", ack, 4'b0100);
    check("wr_rdata_held", rdata, 16'h1234);
    check("wr_mem_data", last_wr_data, 16'hBEEF);
    check("wr_mem_waddr", last_wr_addr, 16'h0010);
    tick();
    check("wr_ack_pulse", ack, 4'b0000);

    // Round-robin with all four requesters held high
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), gnt, rr_exp[k]);
      tick();
      tick();
      check($sformatf("rr_ack%0d", k), ack, rr_exp[k]);
    end
    req = 4'b0000;
    tick();
    check("rr_idle_gnt", gnt, 4'b0000);

    // Lock: requester 1 keeps the bus for three transactions
    do_reset();
    req = 4'b0010;
    lock = 4'b0010;
    tick();
    check("lk_gnt1", gnt, 4'b0010);
    req = 4'b1111;
    tick();
    tick();
    check("lk_ack1", ack, 4'b0010);
    tick();
    check("lk_gnt2", gnt, 4'b0010);
    tick();
    tick();
    check("lk_ack2", ack, 4'b0010);
    tick();
    check("lk_gnt3", gnt, 4'b0010);
    tick();
    tick();
    check("lk_ack3", ack, 4'b0010);
    lock = 4'b0000;
    tick();
    check("lk_release_gnt", gnt, post_lock_exp);
    req = 4'b0000;
    tick();
    tick();
    check("lk_release_ack", ack, post_lock_exp);
    tick();

    // Reset asserted during DATA
    req = 4'b0001;
    req_addr[15:0] = 16'h0033;
    tick();
    tick();
    check("mr_gnt_data", gnt, 4'b0001);
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check("mr_gnt", gnt, 4'b0000);
    check("mr_ack", ack, 4'b0000);
    check("mr_busy", busy, 1'b0);
    check("mr_mem_addr", mem_addr, 16'h0000);
    check("mr_rdata", rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mr_no_ack", ack, 4'b0000);
    req = 4'b0001;
    req_addr[15:0] = 16'h0041;
    tick();
    check("mr2_gnt", gnt, 4'b0001);
    tick();
    tick();
    check("mr2_ack", ack, 4'b0001);
    check("mr2_rdata", rdata, 16'h5678);
    req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
